// File: rtl/gf_inv_seq.sv
// Sequential GF(2^M) inverter/divider: q = a * b^(2^M-2) by iterated square-and-multiply.
// One squarer feeds one multiplier; M-1 CALC cycles per result, valid/ready on both sides.
module gf_inv_seq #(
    parameter int           M    = 8,
    parameter logic [M:0]   POLY = 9'h11B
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_a,
    input  logic [M-1:0] in_b,
    input  logic         in_div,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_q,
    output logic         out_dz,
    output logic [1:0]   dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The requester holds in_valid and operands until accepted; out_q/out_dz hold while out_ready=0.

    localparam int            CW       = (M > 2) ? $clog2(M) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 2);
    localparam logic [M-1:0]  ONE      = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [M-1:0]  sq_q, sq_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;
    logic [M-1:0]  sq2;
    logic [M-1:0]  prod;

    // Carry-less shift-and-add multiply, reducing by POLY whenever the shifted operand overflows.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] p;
        logic [M-1:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < M; i++) begin
            if (y[i]) begin
                p = p ^ t;
            end
            t = {t[M-2:0], 1'b0} ^ (t[M-1] ? POLY[M-1:0] : {M{1'b0}});
        end
        return p;
    endfunction

    assign sq2  = gf_mul(sq_q, sq_q);
    assign prod = gf_mul(acc_q, sq2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sq_d    = in_b;
                    acc_d   = in_div ? in_a : ONE;
                    dz_d    = (in_b == '0);
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // acc accumulates b^(2^i) for i = 1..M-1, i.e. b^(2^M-2) = b^-1.
                sq_d  = sq2;
                acc_d = prod;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_q       = dz_q ? '0 : acc_q;
    assign out_dz      = dz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gf_inv_seq.sv
// Bench for gf_inv_seq: M=8/AES and M=4/0x13 instances checked against a search-based field model.
module tb_gf_inv_seq;

    logic       clk;
    logic       rst_n;
    int         cyc;
    int         errors;
    int         checks;

    // M=8 instance
    logic       v8, rdy8, div8, ov8, dz8;
    logic [7:0] a8, b8, q8;
    logic [1:0] st8;
    // M=4 instance
    logic       v4, rdy4, div4, ov4, dz4;
    logic [3:0] a4, b4, q4;
    logic [1:0] st4;

    logic       or_rand, or_fix, or_rnd8, or_rnd4;
    wire        or8 = or_rand ? or_rnd8 : or_fix;
    wire        or4 = or_rand ? or_rnd4 : or_fix;

    logic [8:0] exp8_q[$];
    int         acc8_q[$];
    logic [4:0] exp4_q[$];
    int         acc4_q[$];
    logic       ov8_prev, ov4_prev;

    gf_inv_seq #(.M(8), .POLY(9'h11B)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
        .in_div(div8), .out_valid(ov8), .out_ready(or8), .out_q(q8), .out_dz(dz8),
        .dbg_state_o(st8)
    );

    gf_inv_seq #(.M(4), .POLY(5'h13)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_a(a4), .in_b(b4),
        .in_div(div4), .out_valid(ov4), .out_ready(or4), .out_q(q4), .out_dz(dz4),
        .dbg_state_o(st4)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        or_rnd8 = ($urandom_range(0, 3) != 0);
        or_rnd4 = ($urandom_range(0, 3) != 0);
    end

    // ---------------- reference model ----------------
    function automatic int gmul(input int m, input int poly, input int x, input int y);
        int p;
        p = 0;
        for (int i = 0; i < m; i++) if ((y >> i) & 1) p = p ^ (x << i);
        for (int i = 2 * m - 2; i >= m; i--) if ((p >> i) & 1) p = p ^ (poly << (i - m));
        return p;
    endfunction

    function automatic int ginv(input int m, input int poly, input int b);
        if (b == 0) return 0;
        for (int x = 1; x < (1 << m); x++) if (gmul(m, poly, b, x) == 1) return x;
        return 0;
    endfunction

    // Returns {dz, q}.
    function automatic int model(input int m, input int poly, input int a, input int b, input int div);
        if (b == 0) return 1 << m;
        return (div != 0) ? gmul(m, poly, a, ginv(m, poly, b)) : ginv(m, poly, b);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // ---------------- drivers (called at a negedge, return at a negedge) ----------------
    task automatic send8(input int a, input int b, input int div, output int acc_e);
        int n;
        n = 0;
        v8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; div8 = div[0];
        while (!rdy8 && n < 200) begin @(negedge clk); n++; end
        acc_e = cyc + 1;
        if (!rdy8) begin
            fail_now("accept_timeout8");
        end else begin
            exp8_q.push_back(9'(model(8, 'h11B, a, b, div)));
            acc8_q.push_back(acc_e);
        end
        @(negedge clk);
        v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); div8 = 1'($urandom);
    endtask

    task automatic send4(input int a, input int b, input int div);
        int n;
        n = 0;
        v4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; div4 = div[0];
        while (!rdy4 && n < 200) begin @(negedge clk); n++; end
        if (!rdy4) begin
            fail_now("accept_timeout4");
        end else begin
            exp4_q.push_back(5'(model(4, 'h13, a, b, div)));
            acc4_q.push_back(cyc + 1);
        end
        @(negedge clk);
        v4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (((which == 8) ? exp8_q.size() : exp4_q.size()) != 0 && n < 2000) begin
            @(negedge clk); n++;
        end
        if (n >= 2000) fail_now((which == 8) ? "drain8" : "drain4");
    endtask

    // ---------------- scoreboard / compare processes ----------------
    always begin
        @(negedge clk); #1;
        if (rst_n && ov8) begin
            if (exp8_q.size() == 0) begin
                fail_now("spurious_valid8");
            end else begin
                if (!ov8_prev) check("latency8", cyc - acc8_q[0], 7);
                check("q8", int'(q8), int'(exp8_q[0][7:0]));
                check("dz8", int'(dz8), int'(exp8_q[0][8]));
                if (or8) begin void'(exp8_q.pop_front()); void'(acc8_q.pop_front()); end
            end
        end
        ov8_prev = ov8;
    end

    always begin
        @(negedge clk); #1;
        if (rst_n && ov4) begin
            if (exp4_q.size() == 0) begin
                fail_now("spurious_valid4");
            end else begin
                if (!ov4_prev) check("latency4", cyc - acc4_q[0], 3);
                check("q4", int'(q4), int'(exp4_q[0][3:0]));
                check("dz4", int'(dz4), int'(exp4_q[0][4]));
                if (or4) begin void'(exp4_q.pop_front()); void'(acc4_q.pop_front()); end
            end
        end
        ov4_prev = ov4;
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc_e, prev_acc, hs, n;
        logic [7:0] held_q;
        logic       held_dz;
        errors = 0; checks = 0;
        rst_n = 1'b0; or_rand = 1'b0; or_fix = 1'b1;
        v8 = 0; a8 = 0; b8 = 0; div8 = 0; v4 = 0; a4 = 0; b4 = 0; div4 = 0;
        ov8_prev = 0; ov4_prev = 0;
        repeat (3) @(negedge clk);

        check("rst_in_ready8", int'(rdy8), 1);
        check("rst_out_valid8", int'(ov8), 0);
        check("rst_out_q8", int'(q8), 0);
        check("rst_out_dz8", int'(dz8), 0);
        check("rst_state8", int'(st8), 0);
        check("rst_in_ready4", int'(rdy4), 1);
        check("rst_out_valid4", int'(ov4), 0);
        rst_n = 1'b1;

        // Pin the model to hand-computed field values.
        check("model_inv02", ginv(8, 'h11B, 'h02), 'h8D);
        check("model_inv03", ginv(8, 'h11B, 'h03), 'hF6);
        check("model_inv53", ginv(8, 'h11B, 'h53), 'hCA);
        check("model_div0203", model(8, 'h11B, 'h02, 'h03, 1), 'hF7);
        check("model_div0303", model(8, 'h11B, 'h03, 'h03, 1), 'h01);
        check("model_div0102", model(8, 'h11B, 'h01, 'h02, 1), 'h8D);
        check("model_dz", model(8, 'h11B, 'h5A, 'h00, 1), 'h100);
        check("model_inv4_2", ginv(4, 'h13, 2), 9);
        check("model_inv4_F", ginv(4, 'h13, 'hF), 8);

        // Directed vectors.
        @(negedge clk);
        send8('h00, 'h02, 0, acc_e); drain(8);
        send8('h00, 'h03, 0, acc_e); drain(8);
        send8('h00, 'h53, 0, acc_e); drain(8);
        send8('h5A, 'h00, 1, acc_e); drain(8);
        send8('h00, 'h07, 1, acc_e); drain(8);
        send8('h02, 'h03, 1, acc_e); drain(8);
        send8('h03, 'h03, 1, acc_e); drain(8);
        send8('h01, 'h02, 1, acc_e); drain(8);

        // Exhaustive inverse sweep, back-to-back; accept spacing must be M+1.
        prev_acc = 0;
        for (int b = 1; b < 256; b++) begin
            send8(0, b, 0, acc_e);
            if (b > 1) check("throughput8", acc_e - prev_acc, 9);
            prev_acc = acc_e;
        end
        drain(8);

        // Random mixed traffic with random out_ready on both instances.
        or_rand = 1'b1;
        for (int i = 0; i < 120; i++) begin
            send8($urandom_range(0, 255), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255),
                  $urandom_range(0, 1), acc_e);
        end
        drain(8);
        for (int i = 0; i < 40; i++) begin
            send4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
        end
        drain(4);
        or_rand = 1'b0;
        or_fix = 1'b1;

        // Backpressure in DONE for 20 cycles.
        or_fix = 1'b0;
        send8('h37, 'h9A, 1, acc_e);
        n = 0;
        while (!ov8 && n < 50) begin @(negedge clk); n++; end
        if (!ov8) fail_now("bp_wait_valid");
        held_q = q8; held_dz = dz8;
        for (int i = 0; i < 20; i++) begin
            check("bp_in_ready", int'(rdy8), 0);
            check("bp_out_valid", int'(ov8), 1);
            check("bp_q_stable", int'(q8), int'(held_q));
            check("bp_dz_stable", int'(dz8), int'(held_dz));
            @(negedge clk);
        end
        or_fix = 1'b1;
        hs = cyc + 1;
        send8('h11, 'h22, 1, acc_e);
        check("bp_next_accept", acc_e - hs, 1);
        drain(8);

        // Asynchronous reset mid-CALC.
        send8(0, 'h03, 0, acc_e);
        while (cyc < acc_e + 3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", int'(rdy8), 1);
        check("midreset_out_valid", int'(ov8), 0);
        check("midreset_state", int'(st8), 0);
        exp8_q.delete(); acc8_q.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post_reset_no_valid", int'(ov8), 0);
        end
        send8(0, 'h03, 0, acc_e); drain(8);

        // M=4 directed.
        send4(0, 2, 0); drain(4);
        send4(0, 'hF, 0); drain(4);
        send4(5, 0, 1); drain(4);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
